// File: rtl/conv_ternary_pad_engine.sv
// Ternary-weight convolution: FILTER_K filters over an IMG_D-channel image with an optional zero border.
// Latency: FILTER_H*FILTER_W+2 cycles per output pixel (one tap per cycle, one drain cycle, one present cycle).
// Backpressure: a result is held in OUT while res_rdy=0, and no image reads are issued during that time.
module conv_ternary_pad_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_W      = 8,
  parameter int IMG_H      = 8,
  parameter int IMG_D      = 4,
  parameter int FILTER_W   = 3,
  parameter int FILTER_H   = 3,
  parameter int FILTER_K   = 8,
  parameter int STRIDE_W   = 1,
  parameter int STRIDE_H   = 1,
  parameter int PAD        = 0,
  localparam int RESULT_W              = (IMG_W + 2*PAD - FILTER_W) / STRIDE_W + 1,
  localparam int RESULT_H              = (IMG_H + 2*PAD - FILTER_H) / STRIDE_H + 1,
  localparam int IMG_RAM_ADDR_WIDTH    = $clog2(IMG_W*IMG_H),
  localparam int RESULT_RAM_ADDR_WIDTH = $clog2(RESULT_W*RESULT_H),
  localparam int ACC_WIDTH             = DATA_WIDTH + $clog2(IMG_D*FILTER_H*FILTER_W) + 1
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic                                        start,
  input  logic                                        relu_en,
  input  logic [2*FILTER_K*IMG_D*FILTER_H*FILTER_W-1:0] fil,
  output logic                                        busy,
  output logic                                        done,
  output logic [IMG_RAM_ADDR_WIDTH-1:0]               img_rdaddress,
  output logic                                        img_rden,
  input  logic [DATA_WIDTH*IMG_D-1:0]                 img_data_in,
  output logic                                        res_val,
  input  logic                                        res_rdy,
  output logic [DATA_WIDTH*FILTER_K-1:0]              res_data,
  output logic [RESULT_RAM_ADDR_WIDTH-1:0]            res_addr
);

  localparam int NTAP  = FILTER_H * FILTER_W;
  localparam int OW_W  = $clog2(RESULT_W + 1);
  localparam int OH_W  = $clog2(RESULT_H + 1);
  localparam int FW_W  = $clog2(FILTER_W + 1);
  localparam int FH_W  = $clog2(FILTER_H + 1);
  localparam int TAP_W = $clog2(NTAP + 1);

  // Saturation bounds expressed at accumulator width; ~max is the most negative DATA_WIDTH value.
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((1 << (DATA_WIDTH-1)) - 1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_LAST, S_OUT} state_t;

  state_t                       r_state;
  state_t                       w_state_nxt;
  logic [OW_W-1:0]              r_ow;
  logic [OH_W-1:0]              r_oh;
  logic [FW_W-1:0]              r_fw;
  logic [FH_W-1:0]              r_fh;
  logic                         r_relu;
  logic                         r_tap_vld;
  logic [TAP_W-1:0]             r_tap_d;
  logic signed [ACC_WIDTH-1:0]  r_acc [FILTER_K];

  logic                         w_tap_last;
  logic                         w_pix_last;
  logic                         w_in_range;
  int                           w_x;
  int                           w_y;
  logic [1:0]                   w_code;
  logic signed [ACC_WIDTH-1:0]  w_pix;
  logic signed [ACC_WIDTH-1:0]  w_acc_add [FILTER_K];
  logic signed [ACC_WIDTH-1:0]  w_v;
  logic [DATA_WIDTH*FILTER_K-1:0] w_res_dat;

  assign w_tap_last = (r_fh == FH_W'(FILTER_H-1)) && (r_fw == FW_W'(FILTER_W-1));
  assign w_pix_last = (r_ow == OW_W'(RESULT_W-1)) && (r_oh == OH_W'(RESULT_H-1));

  // Input coordinate of the current tap; anything outside the image is border padding.
  always_comb begin
    w_x        = int'(r_ow) * STRIDE_W + int'(r_fw) - PAD;
    w_y        = int'(r_oh) * STRIDE_H + int'(r_fh) - PAD;
    w_in_range = (w_x >= 0) && (w_x < IMG_W) && (w_y >= 0) && (w_y < IMG_H);
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_FETCH;
      S_FETCH: if (w_tap_last) w_state_nxt = S_LAST;
      S_LAST:  w_state_nxt = S_OUT;
      S_OUT:   if (res_rdy) w_state_nxt = w_pix_last ? S_IDLE : S_FETCH;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from state and counters; read address is only driven for real taps.
  always_comb begin
    busy          = (r_state != S_IDLE);
    done          = 1'b0;
    img_rden      = 1'b0;
    img_rdaddress = '0;
    res_val       = 1'b0;
    res_data      = '0;
    res_addr      = RESULT_RAM_ADDR_WIDTH'(int'(r_ow) + int'(r_oh) * RESULT_W);
    case (r_state)
      S_FETCH: begin
        if (w_in_range) begin
          img_rden      = 1'b1;
          img_rdaddress = IMG_RAM_ADDR_WIDTH'(w_x + w_y * IMG_W);
        end
      end
      S_OUT: begin
        res_val  = 1'b1;
        res_data = w_res_dat;
        done     = res_rdy && w_pix_last;
      end
      default: ;
    endcase
  end

  // Position/tap counters, relu latch, and the one-cycle delayed tap marker for the read data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ow      <= '0;
      r_oh      <= '0;
      r_fw      <= '0;
      r_fh      <= '0;
      r_relu    <= 1'b0;
      r_tap_vld <= 1'b0;
      r_tap_d   <= '0;
    end else begin
      r_tap_vld <= img_rden;
      r_tap_d   <= TAP_W'(int'(r_fh) * FILTER_W + int'(r_fw));
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_ow   <= '0;
            r_oh   <= '0;
            r_fw   <= '0;
            r_fh   <= '0;
            r_relu <= relu_en;
          end
        end
        S_FETCH: begin
          if (w_tap_last) begin
            r_fw <= '0;
            r_fh <= '0;
          end else if (r_fw == FW_W'(FILTER_W-1)) begin
            r_fw <= '0;
            r_fh <= r_fh + FH_W'(1);
          end else begin
            r_fw <= r_fw + FW_W'(1);
          end
        end
        S_OUT: begin
          if (res_rdy && !w_pix_last) begin
            if (r_ow == OW_W'(RESULT_W-1)) begin
              r_ow <= '0;
              r_oh <= r_oh + OH_W'(1);
            end else begin
              r_ow <= r_ow + OW_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Per-filter contribution of the tap whose pixels are arriving this cycle, summed over channels.
  always_comb begin
    w_code = 2'b00;
    w_pix  = '0;
    for (int k = 0; k < FILTER_K; k++) begin
      w_acc_add[k] = '0;
      for (int d = 0; d < IMG_D; d++) begin
        w_code = fil[2*((k*IMG_D + d)*NTAP + int'(r_tap_d)) +: 2];
        w_pix  = {{(ACC_WIDTH-DATA_WIDTH){img_data_in[d*DATA_WIDTH + DATA_WIDTH-1]}},
                  img_data_in[d*DATA_WIDTH +: DATA_WIDTH]};
        if (w_code == 2'b01)      w_acc_add[k] = w_acc_add[k] + w_pix;
        else if (w_code == 2'b11) w_acc_add[k] = w_acc_add[k] - w_pix;
      end
    end
  end

  // Accumulators: cleared at the start of every output pixel, updated when read data is valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < FILTER_K; k++) r_acc[k] <= '0;
    end else if ((r_state == S_IDLE && start) || (r_state == S_OUT && res_rdy)) begin
      for (int k = 0; k < FILTER_K; k++) r_acc[k] <= '0;
    end else if (r_tap_vld) begin
      for (int k = 0; k < FILTER_K; k++) r_acc[k] <= r_acc[k] + w_acc_add[k];
    end
  end

  // Optional relu, then clamp each accumulator to the signed DATA_WIDTH range.
  always_comb begin
    w_v       = '0;
    w_res_dat = '0;
    for (int k = 0; k < FILTER_K; k++) begin
      w_v = r_acc[k];
      if (r_relu && (w_v < 0)) w_v = '0;
      if (w_v > SAT_MAX)      w_v = SAT_MAX;
      else if (w_v < SAT_MIN) w_v = SAT_MIN;
      w_res_dat[k*DATA_WIDTH +: DATA_WIDTH] = w_v[DATA_WIDTH-1:0];
    end
  end

endmodule
